// File: rtl/shared_timer_pkg.sv
// rtl/shared_timer_pkg.sv - shared timer arbiter types: FSM state encoding and owner index width.
package shared_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_NREQ = 4;

    function automatic int owner_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    localparam int OWNER_W = owner_width(DEFAULT_NREQ);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter; search starts one past ptr.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    int idx;

    // Scan farthest-to-nearest so the requester closest after ptr overwrites the rest.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_timer_arbiter.sv
// rtl/shared_timer_arbiter.sv - one down-counter shared by NREQ requesters; optional abort port via SHARED_TIMER_ABORT_EN.
module shared_timer_arbiter
    import shared_timer_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int INC  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*N-1:0]       req_len,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [N-1:0]            count
`ifdef SHARED_TIMER_ABORT_EN
    ,
    input  logic [NREQ-1:0]         abort
`endif
);

    localparam int            OW   = $clog2(NREQ);
    localparam logic [N-1:0]  STEP = N'(INC);

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [NREQ-1:0] gnt;
    logic [OW-1:0]   gnt_idx;
    logic [N-1:0]    win_len;
    logic            accept;
    logic            kill;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (OW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign win_len = req_len[gnt_idx*N +: N];
    assign accept  = (state == IDLE) && (|gnt) && !rst;

`ifdef SHARED_TIMER_ABORT_EN
    assign kill = (state != IDLE) && abort[owner];
`else
    assign kill = 1'b0;
`endif

    assign req_ready = (state == IDLE && !rst) ? gnt : '0;
    assign busy      = (state != IDLE) && !rst;
    // An abort landing on the DONE cycle swallows the pulse.
    assign done      = (state == DONE && !kill && !rst) ? (NREQ'(1) << owner) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            owner <= '0;
            ptr   <= OW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        count <= win_len;
                        owner <= gnt_idx;
                        ptr   <= gnt_idx;
                        state <= (win_len != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (kill) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count > STEP) begin
                        count <= count - STEP;
                    end else begin
                        count <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    count <= '0;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// tb/tb_shared_timer_arbiter.sv - randomized bench: INC=1 and INC=4 instances against a job-level reference model.
module tb_shared_timer_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_len;
    logic [NREQ-1:0]   abort_s;

    logic [NREQ-1:0]   rdy    [2];
    logic [NREQ-1:0]   dn     [2];
    logic              bsy    [2];
    logic [1:0]        own    [2];
    logic [N-1:0]      cnt    [2];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one outstanding job per instance, described by accept offset and length.
    bit m_busy [2];
    int m_k    [2];
    int m_len  [2];
    int m_own  [2];
    int m_last [2];
    int m_d    [2];
    int inc_of [2] = '{1, 4};

    always #5 clk = ~clk;

    shared_timer_arbiter #(.N(N), .NREQ(NREQ), .INC(1)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (rdy[0]),
        .done      (dn[0]),
        .busy      (bsy[0]),
        .owner     (own[0]),
        .count     (cnt[0])
`ifdef SHARED_TIMER_ABORT_EN
        ,
        .abort     (abort_s)
`endif
    );

    shared_timer_arbiter #(.N(N), .NREQ(NREQ), .INC(4)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (rdy[1]),
        .done      (dn[1]),
        .busy      (bsy[1]),
        .owner     (own[1]),
        .count     (cnt[1])
`ifdef SHARED_TIMER_ABORT_EN
        ,
        .abort     (abort_s)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int winner(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ*N-1:0] lens4(input int a, input int b, input int c, input int d);
        logic [NREQ*N-1:0] l;
        l = {N'(d), N'(c), N'(b), N'(a)};
        return l;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_k[d]    = 0;
            m_len[d]  = 0;
            m_own[d]  = 0;
            m_last[d] = NREQ - 1;
            m_d[d]    = 0;
        end
    endtask

    task automatic step(input logic r, input logic [NREQ-1:0] v,
                        input logic [NREQ*N-1:0] lens, input logic [NREQ-1:0] ab);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_len   = lens;
        abort_s   = ab;
        #1;
        for (int d = 0; d < 2; d++) begin
            int w;
            int ec;
            logic [NREQ-1:0] er;
            logic [NREQ-1:0] ed;
            logic eb;
            logic kill;
            w    = winner(v, m_last[d]);
            er   = '0;
            ed   = '0;
            eb   = 1'b0;
            ec   = 0;
            kill = 1'b0;
`ifdef SHARED_TIMER_ABORT_EN
            kill = m_busy[d] && ab[m_own[d]];
`endif
            if (m_busy[d]) begin
                eb = 1'b1;
                if (m_k[d] == m_d[d]) begin
                    if (!kill) ed[m_own[d]] = 1'b1;
                end else begin
                    ec = m_len[d] - (m_k[d] - 1) * inc_of[d];
                    if (ec < 0) ec = 0;
                end
            end else if (w >= 0) begin
                er[w] = 1'b1;
            end
            if (r) begin
                er = '0;
                ed = '0;
                eb = 1'b0;
            end
            check($sformatf("i%0d.req_ready", d), 64'(rdy[d]), 64'(er));
            check($sformatf("i%0d.done", d),      64'(dn[d]),  64'(ed));
            check($sformatf("i%0d.busy", d),      64'(bsy[d]), 64'(eb));
            if (!r) begin
                check($sformatf("i%0d.count", d), 64'(cnt[d]), 64'(ec));
                check($sformatf("i%0d.owner", d), 64'(own[d]), 64'(m_own[d]));
            end
            // Advance the model to the next cycle.
            if (r) begin
                m_busy[d] = 1'b0;
                m_own[d]  = 0;
                m_last[d] = NREQ - 1;
            end else if (m_busy[d]) begin
                if (kill || m_k[d] == m_d[d]) m_busy[d] = 1'b0;
                else m_k[d]++;
            end else if (w >= 0) begin
                m_busy[d] = 1'b1;
                m_k[d]    = 1;
                m_len[d]  = int'(lens[w*N +: N]);
                m_own[d]  = w;
                m_last[d] = w;
                m_d[d]    = (m_len[d] + inc_of[d] - 1) / inc_of[d] + 1;
            end
        end
    endtask

    initial begin
        logic [NREQ*N-1:0] l;
        logic [NREQ-1:0]   v;
        logic [NREQ-1:0]   ab;
        logic              r;
        rst       = 1'b1;
        req_valid = '0;
        req_len   = '0;
        abort_s   = '0;
        model_reset();

        step(1'b1, 4'b0000, '0, '0);
        step(1'b1, 4'b0000, '0, '0);

        // Single job on requester 2, length 5; the INC=4 instance sees the same job.
        step(1'b0, 4'b0100, lens4(0, 0, 5, 0), '0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000, lens4(9, 9, 9, 9), '0);

        // Zero length on requester 0.
        step(1'b0, 4'b0001, lens4(0, 0, 0, 0), '0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, '0, '0);

        // Everyone requesting continuously with length 1.
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1111, lens4(1, 1, 1, 1), '0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, '0, '0);

        // Length 10 on requester 1, then reset while still counting.
        step(1'b0, 4'b0010, lens4(0, 10, 0, 0), '0);
        for (int i = 0; i < 7; i++) step(1'b0, 4'b0000, '0, '0);
        step(1'b1, 4'b0000, '0, '0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, lens4(2, 2, 2, 2), '0);

`ifdef SHARED_TIMER_ABORT_EN
        // Abort aimed at a non-owner, then at the owner.
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, '0, '0);
        step(1'b0, 4'b0001, lens4(3, 0, 0, 0), '0);
        step(1'b0, 4'b0000, '0, 4'b1110);
        step(1'b0, 4'b0000, '0, 4'b0001);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, '0, '0);
`endif

        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            v  = 4'($urandom);
            if ($urandom_range(0, 2) == 0) v = '0;
            for (int j = 0; j < NREQ; j++) l[j*N +: N] = N'($urandom_range(0, 12));
            ab = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            step(r, v, l, ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
